sdram_field_writer: RTL and testbench



---
 rtl/sdram_field_writer.sv | 179 +++++++++++++++++
 tb/tb_sdram_field_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_field_writer.sv
// Crops a field/line-marked pixel stream to an active window and feeds one SDRAM write port.
// Optional field statistics outputs (oLAST_COUNT, oDROP_COUNT) exist when SDRAM_FIELD_WRITER_STATS_EN is defined.
module sdram_field_writer #(
  parameter int          H_START     = 0,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_START     = 0,
  parameter int          V_ACTIVE    = 240,
  parameter logic [21:0] BASE0       = 22'h000000,
  parameter logic [21:0] BASE1       = 22'h100000,
  parameter int          BURST       = 128,
  parameter int          LOAD_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] iDATA,
  input  logic        iDVAL,
  input  logic        iSOF,
  input  logic        iSOL,
  input  logic        iFIELD,
  input  logic        iENABLE,
  input  logic        WR_FULL,
  output logic [15:0] WR_DATA,
  output logic        WR,
  output logic [21:0] WR_ADDR,
  output logic [21:0] WR_MAX_ADDR,
  output logic [8:0]  WR_LENGTH,
  output logic        WR_LOAD,
  output logic        oOVF,
  output logic        oBUSY,
`ifdef SDRAM_FIELD_WRITER_STATS_EN
  output logic [19:0] oLAST_COUNT,
  output logic [15:0] oDROP_COUNT,
`endif
  output logic [2:0]  oSTATE
);
  localparam logic [19:0] TOTAL   = 20'(H_ACTIVE * V_ACTIVE);
  localparam logic [11:0] H_LO    = 12'(H_START);
  localparam logic [11:0] H_HI    = 12'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO    = 11'(V_START);
  localparam logic [10:0] V_HI    = 11'(V_START + V_ACTIVE);
  localparam logic [2:0]  LD_LAST = 3'(LOAD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_ACTIVE = 3'd2, S_DROP = 3'd3, S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [19:0] wcount_q, wcount_d;
  logic [2:0]  ld_cnt_q, ld_cnt_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wr_q, wr_d;
  logic [21:0] addr_q, addr_d, max_q, max_d;
  logic        ovf_q, ovf_d;
  logic [21:0] base;
  logic        in_win, accept, ld_done;

  // Write handshake: WR is a one-cycle strobe issued the cycle after an accepted pixel;
  // WR_FULL is sampled on the pixel cycle itself, and a full FIFO drops that pixel.
  assign in_win  = iDVAL && !iSOF && !iSOL &&
                   ({1'b0, h_cnt_q} >= H_LO) && ({1'b0, h_cnt_q} < H_HI) &&
                   ({1'b0, v_cnt_q} >= V_LO) && ({1'b0, v_cnt_q} < V_HI);
  assign ld_done = (state_q == S_LOAD) && (ld_cnt_q == LD_LAST) && !iSOF;
  assign accept  = (state_q == S_ACTIVE) && in_win && !WR_FULL;
  assign base    = iFIELD ? BASE1 : BASE0;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (iSOF) begin
      state_d = iENABLE ? S_LOAD : S_IDLE;
    end else begin
      case (state_q)
        S_LOAD:   if (ld_done) state_d = S_ACTIVE;
        S_ACTIVE: begin
          if (in_win && WR_FULL)                    state_d = S_DROP;
          else if (accept && (wcount_q + 20'd1 == TOTAL)) state_d = S_DONE;
        end
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    WR_LOAD = (state_q == S_LOAD);
    oBUSY   = (state_q == S_LOAD) || (state_q == S_ACTIVE);
    oSTATE  = state_q;
  end

  always_comb begin
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    wcount_d  = wcount_q;
    wr_data_d = wr_data_q;
    wr_d      = accept;
    addr_d    = addr_q;
    max_d     = max_q;
    ovf_d     = ovf_q;
    ld_cnt_d  = ((state_q == S_LOAD) && !iSOF) ? ld_cnt_q + 3'd1 : 3'd0;
    if (iSOF) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (iSOL) begin
      h_cnt_d = '0;
      if (v_cnt_q != 10'h3FF) v_cnt_d = v_cnt_q + 10'd1;
    end else if (iDVAL && (h_cnt_q != 11'h7FF)) begin
      h_cnt_d = h_cnt_q + 11'd1;
    end
    if (accept) begin
      wr_data_d = iDATA;
      wcount_d  = wcount_q + 20'd1;
    end
    if (ld_done) begin
      wcount_d = '0;
      ovf_d    = 1'b0;
    end
    if ((state_q == S_ACTIVE) && in_win && WR_FULL) ovf_d = 1'b1;
    if (iSOF && iENABLE) begin
      addr_d = base;
      max_d  = base + 22'(TOTAL);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      wcount_q  <= '0;
      ld_cnt_q  <= '0;
      wr_data_q <= '0;
      wr_q      <= 1'b0;
      addr_q    <= BASE0;
      max_q     <= BASE0 + 22'(TOTAL);
      ovf_q     <= 1'b0;
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      wcount_q  <= wcount_d;
      ld_cnt_q  <= ld_cnt_d;
      wr_data_q <= wr_data_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      max_q     <= max_d;
      ovf_q     <= ovf_d;
    end
  end

  assign WR_DATA     = wr_data_q;
  assign WR          = wr_q;
  assign WR_ADDR     = addr_q;
  assign WR_MAX_ADDR = max_q;
  assign WR_LENGTH   = 9'(BURST);
  assign oOVF        = ovf_q;

`ifdef SDRAM_FIELD_WRITER_STATS_EN
  logic [19:0] last_q;
  logic [15:0] drop_q;

  // Last count is captured only when a field in progress is closed by a new iSOF.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_q <= '0;
      drop_q <= '0;
    end else begin
      if (iSOF && (state_q != S_IDLE)) last_q <= wcount_q;
      if (iSOF && iENABLE) drop_q <= '0;
      else if ((state_q == S_DROP) && in_win && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign oLAST_COUNT = last_q;
  assign oDROP_COUNT = drop_q;
`endif
endmodule

// File: tb/tb_sdram_field_writer.sv
// Bench for sdram_field_writer: directed field scenarios plus random fields, checked every cycle
// against a field-level behavioural model.
module tb_sdram_field_writer;
  localparam int          H_START = 1, H_ACTIVE = 4, V_START = 1, V_ACTIVE = 2;
  localparam int          LOAD_CYCLES = 2, BURST = 128;
  localparam logic [21:0] BASE0 = 22'h000000, BASE1 = 22'h100000;
  localparam int          TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int          P_IDLE = 0, P_LOAD = 1, P_ACTIVE = 2, P_DROP = 3, P_DONE = 4;

  logic        CLK = 1'b0, RESET = 1'b1;
  logic [15:0] iDATA = '0;
  logic        iDVAL = 1'b0, iSOF = 1'b0, iSOL = 1'b0, iFIELD = 1'b0, iENABLE = 1'b0, WR_FULL = 1'b0;
  logic [15:0] WR_DATA;
  logic        WR, WR_LOAD, oOVF, oBUSY;
  logic [21:0] WR_ADDR, WR_MAX_ADDR;
  logic [8:0]  WR_LENGTH;
  logic [2:0]  oSTATE;
`ifdef SDRAM_FIELD_WRITER_STATS_EN
  logic [19:0] oLAST_COUNT;
  logic [15:0] oDROP_COUNT;
`endif

  sdram_field_writer #(
    .H_START(H_START), .H_ACTIVE(H_ACTIVE), .V_START(V_START), .V_ACTIVE(V_ACTIVE),
    .BASE0(BASE0), .BASE1(BASE1), .BURST(BURST), .LOAD_CYCLES(LOAD_CYCLES)
  ) dut (
    .CLK(CLK), .RESET(RESET), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF), .iSOL(iSOL),
    .iFIELD(iFIELD), .iENABLE(iENABLE), .WR_FULL(WR_FULL), .WR_DATA(WR_DATA), .WR(WR),
    .WR_ADDR(WR_ADDR), .WR_MAX_ADDR(WR_MAX_ADDR), .WR_LENGTH(WR_LENGTH), .WR_LOAD(WR_LOAD),
    .oOVF(oOVF), .oBUSY(oBUSY),
`ifdef SDRAM_FIELD_WRITER_STATS_EN
    .oLAST_COUNT(oLAST_COUNT), .oDROP_COUNT(oDROP_COUNT),
`endif
    .oSTATE(oSTATE)
  );

  // Clock / reset
  initial forever #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int wr_pulses = 0, load_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: field phase, window position, per-field write count
  int          m_phase = P_IDLE, m_h = 0, m_v = 0, m_load_left = 0, m_wcount = 0;
  logic        m_wr = 1'b0, m_ovf = 1'b0;
  logic [21:0] m_addr = BASE0, m_max = BASE0 + 22'(TOTAL);
  logic [15:0] exp_q[$];
`ifdef SDRAM_FIELD_WRITER_STATS_EN
  int m_last = 0, m_drop = 0;
`endif

  task automatic model_step();
    bit inwin;
    if (RESET) begin
      m_phase = P_IDLE; m_h = 0; m_v = 0; m_load_left = 0; m_wcount = 0;
      m_wr = 1'b0; m_ovf = 1'b0; m_addr = BASE0; m_max = BASE0 + 22'(TOTAL);
      exp_q.delete();
`ifdef SDRAM_FIELD_WRITER_STATS_EN
      m_last = 0; m_drop = 0;
`endif
      return;
    end
    inwin = iDVAL && !iSOF && !iSOL && m_h >= H_START && m_h < H_START + H_ACTIVE &&
            m_v >= V_START && m_v < V_START + V_ACTIVE;
    m_wr = 1'b0;
    if (iSOF) begin
`ifdef SDRAM_FIELD_WRITER_STATS_EN
      if (m_phase != P_IDLE) m_last = m_wcount;
      if (iENABLE) m_drop = 0;
`endif
      if (iENABLE) begin
        m_addr = iFIELD ? BASE1 : BASE0;
        m_max = m_addr + 22'(TOTAL);
        m_phase = P_LOAD;
        m_load_left = LOAD_CYCLES;
      end else m_phase = P_IDLE;
    end else if (m_phase == P_LOAD) begin
      m_load_left--;
      if (m_load_left == 0) begin m_phase = P_ACTIVE; m_wcount = 0; m_ovf = 1'b0; end
    end else if (m_phase == P_ACTIVE && inwin) begin
      if (WR_FULL) begin m_ovf = 1'b1; m_phase = P_DROP; end
      else begin
        m_wr = 1'b1;
        exp_q.push_back(iDATA);
        m_wcount++;
        if (m_wcount == TOTAL) m_phase = P_DONE;
      end
    end else if (m_phase == P_DROP && inwin) begin
`ifdef SDRAM_FIELD_WRITER_STATS_EN
      if (m_drop < 65535) m_drop++;
`endif
    end
    if (iSOF) begin m_h = 0; m_v = 0; end
    else if (iSOL) begin m_h = 0; if (m_v < 1023) m_v++; end
    else if (iDVAL && m_h < 2047) m_h++;
  endtask

  initial forever begin
    @(posedge CLK or posedge RESET);
    model_step();
  end

  // Scoreboard / compare, away from the active edge
  initial forever begin
    @(negedge CLK);
    check("wr", WR, m_wr);
    check("wr_load", WR_LOAD, m_phase == P_LOAD);
    check("busy", oBUSY, m_phase == P_LOAD || m_phase == P_ACTIVE);
    check("ovf", oOVF, m_ovf);
    check("wr_addr", WR_ADDR, m_addr);
    check("wr_max_addr", WR_MAX_ADDR, m_max);
    check("wr_length", WR_LENGTH, BURST);
    check("state", oSTATE, m_phase);
    if (m_wr && exp_q.size() > 0) check("wr_data", WR_DATA, exp_q.pop_front());
`ifdef SDRAM_FIELD_WRITER_STATS_EN
    check("last_count", oLAST_COUNT, m_last);
    check("drop_count", oDROP_COUNT, m_drop);
`endif
    if (WR) wr_pulses++;
    if (WR_LOAD) load_cyc++;
  end

  // Driver tasks
  task automatic cyc(input bit sof, input bit sol, input bit dval, input bit full);
    iSOF = sof; iSOL = sol; iDVAL = dval; WR_FULL = full; iDATA = 16'($urandom);
    @(posedge CLK); #1;
    iSOF = 1'b0; iSOL = 1'b0; iDVAL = 1'b0; WR_FULL = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic sof(input bit field, input bit en);
    iFIELD = field; iENABLE = en;
    cyc(1, 0, 0, 0);
  endtask

  task automatic line(input int npix, input int full_idx);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < npix; i++) cyc(0, 0, 1, i == full_idx);
  endtask

  task automatic clr();
    wr_pulses = 0; load_cyc = 0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_wr", WR, 0);
    check("rst_wr_data", WR_DATA, 0);
    check("rst_wr_load", WR_LOAD, 0);
    check("rst_busy", oBUSY, 0);
    check("rst_ovf", oOVF, 0);
    check("rst_addr", WR_ADDR, 22'h0);
    check("rst_max", WR_MAX_ADDR, 22'h8);
    check("rst_length", WR_LENGTH, 9'd128);
    check("rst_state", oSTATE, P_IDLE);
    RESET = 1'b0;
    idle(2);

    // Field 0: 3 lines of 6 pixels
    clr(); sof(0, 1);
    repeat (3) line(6, -1);
    idle(3);
    check("t1_pulses", wr_pulses, 8);
    check("t1_load_width", load_cyc, 2);
    check("t1_state_done", oSTATE, P_DONE);
    check("t1_addr", WR_ADDR, 22'h0);
    check("t1_max", WR_MAX_ADDR, 22'h8);

    // Field 1 base
    clr(); sof(1, 1);
    repeat (3) line(6, -1);
    idle(3);
    check("t2_addr", WR_ADDR, 22'h100000);
    check("t2_max", WR_MAX_ADDR, 22'h100008);
    check("t2_pulses", wr_pulses, 8);

    // FIFO full on the third in-window pixel
    clr(); sof(0, 1); idle(2);
    line(6, 3); line(6, -1); idle(2);
    check("t3_pulses", wr_pulses, 2);
    check("t3_ovf", oOVF, 1);
    check("t3_state_drop", oSTATE, P_DROP);
`ifdef SDRAM_FIELD_WRITER_STATS_EN
    check("t3_drop_count", oDROP_COUNT, 5);
`endif
    sof(0, 1);
    check("t3_ovf_sticky_in_load", oOVF, 1);
    idle(2);
    check("t3_ovf_cleared", oOVF, 0);

    // New iSOF after 5 writes
    clr();
    line(6, -1);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    idle(1);
    check("t4_pulses_before", wr_pulses, 5);
    clr(); sof(0, 1);
`ifdef SDRAM_FIELD_WRITER_STATS_EN
    check("t4_last_count", oLAST_COUNT, 5);
`endif
    repeat (3) line(6, -1);
    idle(2);
    check("t4_pulses_restart", wr_pulses, 8);
    check("t4_load_width", load_cyc, 2);

    // Pixel on iSOL and pixels during LOAD are discarded
    clr(); sof(0, 1);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    cyc(0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
    idle(2);
    check("t5_pulses", wr_pulses, 8);
    check("t5_state_done", oSTATE, P_DONE);

    // Disabled field, then reset mid-ACTIVE
    clr(); sof(0, 0);
    repeat (3) line(6, -1);
    idle(2);
    check("t6_pulses", wr_pulses, 0);
    check("t6_load", load_cyc, 0);
    check("t6_busy", oBUSY, 0);
    sof(0, 1); idle(2);
    cyc(0, 1, 0, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    check("t6_wr_before_reset", WR, 1);
    RESET = 1'b1;
    #1;
    check("t6_rst_wr", WR, 0);
    check("t6_rst_busy", oBUSY, 0);
    check("t6_rst_state", oSTATE, P_IDLE);
    check("t6_rst_addr", WR_ADDR, 22'h0);
    check("t6_rst_data", WR_DATA, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    idle(2);

    // Random fields
    for (int f = 0; f < 60; f++) begin
      int nl;
      sof(1'($urandom_range(0, 1)), $urandom_range(0, 5) != 0);
      nl = $urandom_range(0, 4);
      for (int l = 0; l < nl; l++) begin
        int np;
        cyc(0, 1, $urandom_range(0, 3) == 0, 0);
        np = $urandom_range(0, 7);
        for (int p = 0; p < np; p++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          cyc(0, 0, 1, $urandom_range(0, 15) == 0);
        end
      end
      if ($urandom_range(0, 15) == 0) begin
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
      end
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
